// File: rtl/dram_line_pkg.sv
// Shared types and constants for the DRAM line master.
// Covers the FSM state encoding, line geometry and the fixed bus ID.
package dram_line_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WDATA,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_e;

    localparam int         BEATS     = 4;
    localparam int         BEAT_W    = 32;
    localparam int         LINE_W    = 128;
    localparam logic [5:0] ATOP_NONE = 6'd0;
    localparam logic [3:0] ID        = 4'h0;

    function automatic logic is_last(input logic [1:0] beat);
        return beat == 2'(BEATS - 1);
    endfunction

endpackage

// File: rtl/line_beat_shifter.sv
// Line register plus beat index.
// Serialises write lines and assembles read lines one beat at a time.
module line_beat_shifter
    import dram_line_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LINE_W-1:0] wline_i,
    input  logic              beat_clr_i,
    input  logic              step_i,
    input  logic              capture_i,
    input  logic [BEAT_W-1:0] rdata_i,
    output logic [1:0]        beat_o,
    output logic [BEAT_W-1:0] beat_data_o,
    output logic [LINE_W-1:0] line_nxt_o
);

    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;
    logic [1:0]        beat_q;
    logic [1:0]        beat_d;
    logic [6:0]        base;

    assign base = {beat_q, 5'd0};

    always_comb begin
        line_d = line_q;
        beat_d = beat_q;
        if (load_i) begin
            line_d = wline_i;
            beat_d = '0;
        end else begin
            if (capture_i) begin
                line_d[base +: BEAT_W] = rdata_i;
            end
            if (beat_clr_i) begin
                beat_d = '0;
            end else if (step_i) begin
                beat_d = beat_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
            beat_q <= '0;
        end else begin
            line_q <= line_d;
            beat_q <= beat_d;
        end
    end

    assign beat_o      = beat_q;
    assign beat_data_o = line_q[base +: BEAT_W];
    // Includes the beat being captured this cycle, so the final read
    // beat lands in the completed line without an extra cycle.
    assign line_nxt_o  = line_d;

endmodule

// File: rtl/dram_line_master.sv
// One-line-per-command bus initiator: 4-beat write or read bursts,
// response ID/last/completion checking and a one-cycle done pulse.
module dram_line_master
    import dram_line_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_wline,
    output logic         resp_valid,
    output logic [127:0] resp_rline,
    output logic         resp_err,
    output logic         awvalid,
    input  logic         awready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [5:0]   awatop,
    output logic         wvalid,
    input  logic         wready,
    output logic [31:0]  wdata,
    output logic         wlast,
    input  logic         bvalid,
    output logic         bready,
    input  logic [3:0]   bid,
    input  logic         bcomp,
    output logic         arvalid,
    input  logic         arready,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    input  logic         rvalid,
    output logic         rready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic         rlast
);

    state_e       state_q;
    logic [31:0]  addr_q;
    logic         err_q;
    logic         req_ready_q;
    logic         awvalid_q;
    logic         wvalid_q;
    logic         bready_q;
    logic         arvalid_q;
    logic         rready_q;
    logic         resp_valid_q;
    logic [127:0] rline_q;

    logic         accept;
    logic         aw_hs;
    logic         w_hs;
    logic         b_hs;
    logic         ar_hs;
    logic         r_hs;
    logic         last;
    logic         b_err;
    logic         r_err;
    logic [1:0]   beat;
    logic [31:0]  beat_data;
    logic [127:0] line_nxt;

    assign accept = req_valid & req_ready_q;
    assign aw_hs  = awvalid_q & awready;
    assign w_hs   = wvalid_q & wready;
    assign b_hs   = bready_q & bvalid;
    assign ar_hs  = arvalid_q & arready;
    assign r_hs   = rready_q & rvalid;
    assign last   = is_last(beat);
    assign b_err  = (bid != ID) | ~bcomp;
    assign r_err  = (rid != ID) | (rlast != last);

    line_beat_shifter u_shifter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .wline_i     (req_wline),
        .beat_clr_i  (aw_hs | ar_hs),
        .step_i      (w_hs | r_hs),
        .capture_i   (r_hs),
        .rdata_i     (rdata),
        .beat_o      (beat),
        .beat_data_o (beat_data),
        .line_nxt_o  (line_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            rline_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q      <= req_addr & ~32'hF;
                        err_q       <= 1'b0;
                        req_ready_q <= 1'b0;
                        if (req_we) begin
                            awvalid_q <= 1'b1;
                            state_q   <= S_WADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RADDR;
                        end
                    end
                end
                S_WADDR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (w_hs && last) begin
                        wvalid_q <= 1'b0;
                        bready_q <= 1'b1;
                        state_q  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (b_hs) begin
                        err_q        <= err_q | b_err;
                        bready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_RADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    // Burst length is fixed: beat 3 ends it even without rlast.
                    if (r_hs) begin
                        err_q <= err_q | r_err;
                        if (last) begin
                            rready_q     <= 1'b0;
                            resp_valid_q <= 1'b1;
                            rline_q      <= line_nxt;
                            state_q      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rline = rline_q;
    assign resp_err   = err_q;
    assign awvalid    = awvalid_q;
    assign awid       = ID;
    assign awaddr     = addr_q;
    assign awatop     = ATOP_NONE;
    assign wvalid     = wvalid_q;
    assign wdata      = beat_data;
    assign wlast      = wvalid_q & last;
    assign bready     = bready_q;
    assign arvalid    = arvalid_q;
    assign arid       = ID;
    assign araddr     = addr_q;
    assign rready     = rready_q;

endmodule

// File: tb/tb_dram_line_master.sv
// Directed bench for dram_line_master with a transaction-level model
// and a per-cycle compare process.
module tb_dram_line_master;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [127:0] req_wline;
    logic         resp_valid;
    logic [127:0] resp_rline;
    logic         resp_err;
    logic         awvalid;
    logic         awready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [5:0]   awatop;
    logic         wvalid;
    logic         wready;
    logic [31:0]  wdata;
    logic         wlast;
    logic         bvalid;
    logic         bready;
    logic [3:0]   bid;
    logic         bcomp;
    logic         arvalid;
    logic         arready;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic         rvalid;
    logic         rready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic         rlast;

    always #5 clk = ~clk;

    dram_line_master dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wline  (req_wline),
        .resp_valid (resp_valid),
        .resp_rline (resp_rline),
        .resp_err   (resp_err),
        .awvalid    (awvalid),
        .awready    (awready),
        .awid       (awid),
        .awaddr     (awaddr),
        .awatop     (awatop),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .wlast      (wlast),
        .bvalid     (bvalid),
        .bready     (bready),
        .bid        (bid),
        .bcomp      (bcomp),
        .arvalid    (arvalid),
        .arready    (arready),
        .arid       (arid),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rid        (rid),
        .rdata      (rdata),
        .rlast      (rlast)
    );

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wline;
        logic [127:0] rline;
        logic         err;
    } txn_t;

    txn_t expq[$];
    txn_t cur;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;
    int nresp = 0;
    int acc_cyc;
    int resp_cyc;

    // Planned subordinate behaviour for the next transaction(s).
    logic [31:0] plan_rdata [4];
    logic [3:0]  plan_rid   [4];
    logic        plan_rlast [4];
    bit          plan_gap;
    logic [3:0]  plan_bid;
    logic        plan_bcomp;
    int          stall_beat;
    int          stall_n;

    // Observations recorded by the compare process.
    bit           inflight;
    int           wcnt;
    logic [127:0] hold_rline;
    logic [31:0]  w_seen [4];
    logic [31:0]  aw_seen;
    logic         last_err;
    logic [127:0] last_rline;
    bit           p_aw, p_w, p_ar;
    logic [31:0]  p_awaddr, p_wdata, p_araddr;
    logic         p_wlast;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        ncmp++;
        nfail++;
        $display("FAIL %s: got unexpected or missing event", name);
    endtask

    function automatic txn_t expect_txn(input logic we, input logic [31:0] a,
                                        input logic [127:0] wl);
        txn_t t;
        t.we    = we;
        t.addr  = {a[31:4], 4'h0};
        t.wline = wl;
        t.rline = '0;
        t.err   = 1'b0;
        if (we) begin
            t.err = (plan_bid != 4'h0) || !plan_bcomp;
        end else begin
            for (int k = 0; k < 4; k++) begin
                t.rline[32*k +: 32] = plan_rdata[k];
                if (plan_rid[k] != 4'h0 || plan_rlast[k] != (k == 3))
                    t.err = 1'b1;
            end
        end
        return t;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            inflight   = 0;
            wcnt       = 0;
            hold_rline = '0;
            p_aw       = 0;
            p_w        = 0;
            p_ar       = 0;
        end else begin
            if (p_aw) chk("aw_hold", 128'({awvalid, awaddr}), 128'({1'b1, p_awaddr}));
            if (p_w)  chk("w_hold", 128'({wvalid, wlast, wdata}),
                          128'({1'b1, p_wlast, p_wdata}));
            if (p_ar) chk("ar_hold", 128'({arvalid, araddr}), 128'({1'b1, p_araddr}));
            chk("req_ready", 128'(req_ready), 128'(!inflight));
            if (!(resp_valid && inflight && !cur.we))
                chk("rline_stable", resp_rline, hold_rline);
            if (req_valid && req_ready) begin
                if (expq.size() == 0) begin
                    bad("no_model_txn");
                end else begin
                    cur      = expq.pop_front();
                    inflight = 1;
                    wcnt     = 0;
                    acc_cyc  = cyc;
                end
            end
            if (awvalid) begin
                chk("awaddr", 128'(awaddr), 128'(cur.addr));
                chk("aw_fixed", 128'({cur.we, awid, awatop}), 128'({1'b1, 4'h0, 6'h0}));
                aw_seen = awaddr;
            end
            if (arvalid) begin
                chk("araddr", 128'(araddr), 128'(cur.addr));
                chk("ar_fixed", 128'({cur.we, arid}), 128'({1'b0, 4'h0}));
            end
            if (wvalid) begin
                if (wcnt > 3 || !cur.we) begin
                    bad("w_extra");
                end else begin
                    chk("wdata", 128'(wdata), 128'(cur.wline[32*wcnt +: 32]));
                    chk("wlast", 128'(wlast), 128'(wcnt == 3));
                    w_seen[wcnt] = wdata;
                end
                if (wready) wcnt++;
            end
            if (resp_valid) begin
                if (!inflight) begin
                    bad("resp_spurious");
                end else begin
                    chk("resp_err", 128'(resp_err), 128'(cur.err));
                    if (cur.we) begin
                        chk("w_beats", 128'(wcnt), 128'(4));
                    end else begin
                        chk("resp_rline", resp_rline, cur.rline);
                        hold_rline = cur.rline;
                    end
                    inflight   = 0;
                    resp_cyc   = cyc;
                    nresp++;
                    last_err   = resp_err;
                    last_rline = resp_rline;
                end
            end
            p_aw     = awvalid && !awready;
            p_awaddr = awaddr;
            p_w      = wvalid && !wready;
            p_wdata  = wdata;
            p_wlast  = wlast;
            p_ar     = arvalid && !arready;
            p_araddr = araddr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [127:0] wl, input bit hold);
        bit acc = 0;
        expq.push_back(expect_txn(we, a, wl));
        req_we    = we;
        req_addr  = a;
        req_wline = wl;
        req_valid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
            tick();
        end
        if (!acc) bad("accept_timeout");
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic serve(input logic we, input int abort_at);
        int nw    = 0;
        int nr    = 0;
        int stall = stall_n;
        bit bdone = 0;
        bit done  = 0;
        bit gap   = 0;
        awready = 1'b1;
        arready = 1'b1;
        for (int i = 0; i < 80 && !done; i++) begin
            if (abort_at >= 0 && nw == abort_at) begin
                rst    = 1'b1;
                tick();
                rst    = 1'b0;
                wready = 1'b0;
                bvalid = 1'b0;
                @(negedge clk);
                chk("rst_valids", 128'({awvalid, wvalid, arvalid, bready, rready}), 128'(0));
                chk("rst_resp", 128'(resp_valid), 128'(0));
                chk("rst_req_ready", 128'(req_ready), 128'(1));
                tick();
                done = 1;
            end else begin
                if (we) begin
                    wready = !(nw == stall_beat && stall > 0);
                    bvalid = (nw == 4) && !bdone;
                    bid    = plan_bid;
                    bcomp  = plan_bcomp;
                end else begin
                    rvalid = (nr < 4) && !gap;
                    if (nr < 4) begin
                        rdata = plan_rdata[nr];
                        rid   = plan_rid[nr];
                        rlast = plan_rlast[nr];
                    end
                end
                @(negedge clk);
                if (we && wvalid && wready) nw++;
                if (we && wvalid && !wready && nw == stall_beat && stall > 0) stall--;
                if (bvalid && bready) bdone = 1;
                gap = 0;
                if (!we && rvalid && rready) begin
                    nr++;
                    gap = plan_gap;
                end
                if (resp_valid) done = 1;
                tick();
            end
        end
        if (!done) bad("resp_timeout");
        bvalid = 1'b0;
        rvalid = 1'b0;
        wready = 1'b1;
    endtask

    task automatic clean_read_plan(input logic [31:0] base);
        for (int k = 0; k < 4; k++) begin
            plan_rdata[k] = base + 32'(k);
            plan_rid[k]   = 4'h0;
            plan_rlast[k] = (k == 3);
        end
    endtask

    logic [127:0] line1;
    int           n0;
    int           r1;

    initial begin
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = '0; req_wline = '0;
        awready = 0; wready = 0; bvalid = 0; bid = '0; bcomp = 0;
        arready = 0; rvalid = 0; rid = '0; rdata = '0; rlast = 0;
        plan_gap = 0; plan_bid = 4'h0; plan_bcomp = 1'b1;
        stall_beat = 1; stall_n = 0;
        clean_read_plan(32'hA0);
        line1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 128'(req_ready), 128'(1));
        chk("reset_valids", 128'({awvalid, wvalid, arvalid, bready, rready}), 128'(0));
        chk("reset_resp", 128'({resp_valid, resp_err}), 128'(0));
        chk("reset_rline", resp_rline, 128'(0));
        tick();

        issue(1'b1, 32'h0000_1234, line1, 0);
        serve(1'b1, -1);
        chk("t1_latency", 128'(resp_cyc - acc_cyc), 128'(7));
        chk("t1_awaddr", 128'(aw_seen), 128'(32'h0000_1230));
        chk("t1_wdata0", 128'(w_seen[0]), 128'(32'h11111111));
        chk("t1_wdata3", 128'(w_seen[3]), 128'(32'h44444444));
        chk("t1_err", 128'(last_err), 128'(0));

        stall_n = 2;
        n0 = nresp;
        issue(1'b1, 32'h0000_2008, {32'hD, 32'hC, 32'hB, 32'hA}, 0);
        serve(1'b1, -1);
        stall_n = 0;
        chk("t2_nresp", 128'(nresp - n0), 128'(1));
        chk("t2_latency", 128'(resp_cyc - acc_cyc), 128'(9));
        chk("t2_wdata1", 128'(w_seen[1]), 128'(32'hB));

        plan_bcomp = 1'b0;
        issue(1'b1, 32'h0000_3000, line1, 0);
        serve(1'b1, -1);
        plan_bcomp = 1'b1;
        chk("t2b_bcomp_err", 128'(last_err), 128'(1));

        plan_gap = 1;
        issue(1'b0, 32'h0000_0100, '0, 0);
        serve(1'b0, -1);
        chk("t3_rline", last_rline, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        chk("t3_err", 128'(last_err), 128'(0));
        n0 = nresp;
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rid = 4'h0; rlast = 1'b1;
        repeat (3) tick();
        rvalid = 1'b0;
        chk("t3_extra_r", 128'(nresp - n0), 128'(0));

        plan_rid[2] = 4'h1;
        issue(1'b0, 32'h0000_0200, '0, 0);
        serve(1'b0, -1);
        chk("t4_rid_err", 128'(last_err), 128'(1));
        plan_rid[2]   = 4'h0;
        plan_rlast[1] = 1'b1;
        plan_rlast[3] = 1'b0;
        issue(1'b0, 32'h0000_0240, '0, 0);
        serve(1'b0, -1);
        chk("t5_rlast_err", 128'(last_err), 128'(1));
        clean_read_plan(32'hC0);
        plan_gap = 0;
        issue(1'b0, 32'h0000_0280, '0, 0);
        serve(1'b0, -1);
        chk("t6_err_clear", 128'(last_err), 128'(0));
        chk("t6_rline", last_rline, {32'hC3, 32'hC2, 32'hC1, 32'hC0});

        n0 = nresp;
        issue(1'b1, 32'h0000_4000, line1, 0);
        serve(1'b1, 2);
        chk("t7_no_resp", 128'(nresp - n0), 128'(0));
        clean_read_plan(32'hE0);
        issue(1'b0, 32'h0000_0500, '0, 0);
        serve(1'b0, -1);
        chk("t7_read_after", last_rline, {32'hE3, 32'hE2, 32'hE1, 32'hE0});

        clean_read_plan(32'hB0);
        issue(1'b1, 32'h0000_0400, line1, 1);
        req_we    = 1'b0;
        req_addr  = 32'h0000_0300;
        req_wline = '0;
        serve(1'b1, -1);
        r1 = resp_cyc;
        issue(1'b0, 32'h0000_0300, '0, 0);
        chk("t8_b2b_accept", 128'(acc_cyc - r1), 128'(1));
        serve(1'b0, -1);
        chk("t8_rline", last_rline, {32'hB3, 32'hB2, 32'hB1, 32'hB0});

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
